// File: rtl/ex_div_sequencer_pkg.sv
// Shared definitions for the EX-stage divide sequencer: operation
// encodings (funct3[1:0]), FSM state encodings and default width.
package ex_div_sequencer_pkg;

    localparam int DEF_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // DIV and REM treat operands as two's-complement values.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_div_sequencer_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quot} left,
// trial-subtract the divisor and keep the difference when it is
// non-negative, recording the outcome as the new quotient LSB.
module ex_div_sequencer_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Combinational shift, trial subtract and restore decision.
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        rem_next  = '0;
        quot_next = '0;
        shifted   = {rem[XLEN-1:0], quot[XLEN-1]};
        trial     = shifted - {1'b0, divisor};
        if (!trial[XLEN]) begin
            rem_next  = trial;
            quot_next = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = shifted;
            quot_next = {quot[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_sequencer.sv
// Multi-cycle RV32M divide sequencer beside the EX-stage ALU. Accepts a
// DIV/DIVU/REM/REMU from ID/EX, stalls the pipe for XLEN restoring steps
// (or one cycle for divide-by-zero / signed overflow) and returns one
// registered result pulse per accepted request.
module ex_div_sequencer
    import ex_div_sequencer_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_div_valid,
    input  logic [1:0]      id_div_op,
    input  logic [XLEN-1:0] id_reg_rs1_data,
    input  logic [XLEN-1:0] id_reg_rs2_data,
    input  logic            flush,
    output logic            ex_div_stall,
    output logic            ex_div_valid,
    output logic [XLEN-1:0] ex_div_out
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    rem_q;
    logic [XLEN-1:0]  quot_q, dvsr_q;
    logic             is_rem_q, neg_quot_q, neg_rem_q;
    logic             valid_q;
    logic [XLEN-1:0]  out_q;

    logic             accept, signed_op, rs1_neg, rs2_neg, div_zero, overflow, special;
    logic [XLEN-1:0]  rs1_mag, rs2_mag, special_out;
    logic [XLEN:0]    rem_nx;
    logic [XLEN-1:0]  quot_nx, quot_fix, rem_fix, final_out;
    logic             last_step;

    assign accept    = (state_q == DIV_IDLE) && id_div_valid && !flush;
    assign signed_op = op_is_signed(id_div_op);
    assign rs1_neg   = signed_op && id_reg_rs1_data[XLEN-1];
    assign rs2_neg   = signed_op && id_reg_rs2_data[XLEN-1];
    assign rs1_mag   = rs1_neg ? -id_reg_rs1_data : id_reg_rs1_data;
    assign rs2_mag   = rs2_neg ? -id_reg_rs2_data : id_reg_rs2_data;
    assign div_zero  = (id_reg_rs2_data == '0);
    assign overflow  = signed_op && (id_reg_rs1_data == INT_MIN) && (id_reg_rs2_data == '1);
    assign special   = div_zero || overflow;

    // Divide-by-zero and signed overflow are resolved at accept time.
    assign special_out = op_is_rem(id_div_op)
                       ? (div_zero ? id_reg_rs1_data : '0)
                       : (div_zero ? '1 : INT_MIN);

    ex_div_sequencer_div_step #(.XLEN(XLEN)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (dvsr_q),
        .rem_next  (rem_nx),
        .quot_next (quot_nx)
    );

    // Sign correction of the final step: quotient negated on differing
    // operand signs, remainder follows the dividend; both wrap at XLEN.
    assign quot_fix  = neg_quot_q ? -quot_nx : quot_nx;
    assign rem_fix   = neg_rem_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    assign final_out = is_rem_q ? rem_fix : quot_fix;
    assign last_step = (state_q == DIV_CALC) && (cnt_q == '0);

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (accept) state_d = special ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt_q == '0) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    // State, step counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            valid_q <= 1'b0;
            if (accept) begin
                cnt_q <= CNT_LAST;
            end else if (state_q == DIV_CALC && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (accept && special) begin
                valid_q <= 1'b1;
                out_q   <= special_out;
            end else if (last_step && !flush) begin
                valid_q <= 1'b1;
                out_q   <= final_out;
            end
        end
    end

    // Divider datapath: operands latched at accept, one step per CALC cycle.
    // NOTE: datapath registers carry no reset; their contents only matter
    // after an accept loads them, and valid_q qualifies everything visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q      <= '0;
            quot_q     <= rs1_mag;
            dvsr_q     <= rs2_mag;
            is_rem_q   <= op_is_rem(id_div_op);
            neg_quot_q <= rs1_neg ^ rs2_neg;
            neg_rem_q  <= rs1_neg;
        end else if (state_q == DIV_CALC) begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
        end
    end

    assign ex_div_stall = accept || (state_q == DIV_CALC);
    // valid_q is high only in DONE; a flush arriving in that same cycle
    // still has to cancel the pulse, hence the gate.
    assign ex_div_valid = valid_q && !flush;
    assign ex_div_out   = out_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed self-checking bench for ex_div_sequencer: signed/unsigned
// results, special cases, latency and stall window, flush, back-to-back
// issue and asynchronous reset during a divide.
module tb_ex_div_sequencer;
    import ex_div_sequencer_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_div_valid;
    logic [1:0]      id_div_op;
    logic [XLEN-1:0] id_reg_rs1_data;
    logic [XLEN-1:0] id_reg_rs2_data;
    logic            flush;
    logic            ex_div_stall;
    logic            ex_div_valid;
    logic [XLEN-1:0] ex_div_out;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          cyc       = 0;
    int          valid_cyc = 0;
    int          first_cyc = 0;
    logic [31:0] last_out  = '0;

    ex_div_sequencer #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_div_valid    (id_div_valid),
        .id_div_op       (id_div_op),
        .id_reg_rs1_data (id_reg_rs1_data),
        .id_reg_rs2_data (id_reg_rs2_data),
        .flush           (flush),
        .ex_div_stall    (ex_div_stall),
        .ex_div_valid    (ex_div_valid),
        .ex_div_out      (ex_div_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        id_div_valid    = 1'b1;
        id_div_op       = op;
        id_reg_rs1_data = a;
        id_reg_rs2_data = b;
    endtask

    task automatic drop();
        id_div_valid = 1'b0;
    endtask

    // Called in the accept cycle; walks forward to the result pulse,
    // counting stall cycles, with a bounded budget.
    task automatic wait_result(input string tag, input logic [31:0] exp, input int lat);
        int k = 0;
        int stalls = 0;
        bit seen = 1'b0;
        #1;
        while (!seen && k <= 40) begin
            if (ex_div_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (ex_div_stall === 1'b1) stalls++;
                @(negedge clk);
                #1;
                k++;
            end
        end
        check({tag, " seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " stall cycles"}, 32'(stalls), 32'(lat));
        check({tag, " out"}, ex_div_out, exp);
        check({tag, " stall in done"}, 32'(ex_div_stall), 32'd0);
        last_out  = exp;
        valid_cyc = cyc;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(negedge clk);
        issue(op, a, b);
        wait_result(tag, exp, lat);
        drop();
        @(negedge clk);
        #1;
        check({tag, " single pulse"}, 32'(ex_div_valid), 32'd0);
    endtask

    task automatic count_pulses(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (ex_div_valid === 1'b1) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        rst             = 1'b0;
        id_div_valid    = 1'b0;
        id_div_op       = 2'b00;
        id_reg_rs1_data = '0;
        id_reg_rs2_data = '0;
        flush           = 1'b0;

        #1;
        check("reset valid", 32'(ex_div_valid), 32'd0);
        check("reset stall", 32'(ex_div_stall), 32'd0);
        check("reset out", ex_div_out, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Normal divides: signed, unsigned, mixed signs.
        run("div 100/7",      DIV_OP_DIV,  32'd100,        32'd7,          32'd14,         33);
        run("rem 100/7",      DIV_OP_REM,  32'd100,        32'd7,          32'd2,          33);
        run("div -7/2",       DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
        run("rem -7/2",       DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
        run("div 7/-2",       DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
        run("rem 7/-2",       DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);
        run("divu ffffffff/2", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF,  33);
        run("remu ffffffff/2", DIV_OP_REMU, 32'hFFFF_FFFF, 32'd2,          32'd1,          33);
        run("divu min/ffffffff", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

        // Special cases resolved in one cycle.
        run("divu 5/0",       DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        run("rem 5/0",        DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1);
        run("div min/-1",     DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run("rem min/-1",     DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

        // Flush part-way through a divide.
        @(negedge clk);
        issue(DIV_OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush valid low", 32'(ex_div_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        drop();
        #1;
        check("flush idle stall", 32'(ex_div_stall), 32'd0);
        count_pulses("flush no pulse", 40);
        check("flush out held", ex_div_out, last_out);
        run("div 9/3 after flush", DIV_OP_DIV, 32'd9, 32'd3, 32'd3, 33);

        // Back-to-back: next divide already presented during DONE.
        @(negedge clk);
        issue(DIV_OP_DIV, 32'd20, 32'd4);
        wait_result("b2b 20/4", 32'd5, 33);
        first_cyc = valid_cyc;
        issue(DIV_OP_DIV, 32'd21, 32'd5);
        @(negedge clk);
        check("b2b single pulse", 32'(ex_div_valid), 32'd0);
        wait_result("b2b 21/5", 32'd4, 33);
        check("b2b gap", 32'(valid_cyc - first_cyc), 32'd34);
        drop();
        @(negedge clk);
        #1;
        check("b2b done", 32'(ex_div_valid), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        issue(DIV_OP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2;
        drop();
        rst = 1'b0;
        #1;
        check("midreset valid", 32'(ex_div_valid), 32'd0);
        check("midreset stall", 32'(ex_div_stall), 32'd0);
        check("midreset out", ex_div_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        count_pulses("midreset no pulse", 40);
        run("div 6/3 after reset", DIV_OP_DIV, 32'd6, 32'd3, 32'd2, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_div_sequencer.md
Name: ex_div_sequencer

Overview:
Multi-cycle RV32M divide unit attached beside the EX-stage ALU. It sequences an iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and stalls the pipeline while a divide is in flight. It returns one result per accepted request. It sits between the ID/EX operand pipe and the EX result mux, and shares the ID/EX operand buses with the ALU.

Parameters:
XLEN, 32, operand and result width; iteration count equals XLEN.

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-low (asserted when 0)
id_div_valid  input  1  ID/EX holds a divide instruction
id_div_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
id_reg_rs1_data  input  XLEN  dividend
id_reg_rs2_data  input  XLEN  divisor
flush  input  1  pipeline flush; abandon any divide in progress
ex_div_stall  output  1  hold IF/ID/EX; combinational
ex_div_valid  output  1  result valid, one-cycle pulse, registered
ex_div_out  output  XLEN  quotient or remainder, registered

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; counter=0; ex_div_valid=0; ex_div_out=0.
- States: IDLE, CALC, DONE.
- IDLE: accept occurs when id_div_valid=1 and flush=0.
  - Latch op, sign flags and operand magnitudes. Signed ops take the absolute value; unsigned ops pass through.
  - Counter is set to XLEN-1.
  - Special cases skip CALC and go IDLE->DONE, with the result computed at accept:
    - Divisor 0: quotient all ones; remainder = rs1.
    - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000; remainder 0.
  - Otherwise go IDLE->CALC.
- CALC: one restoring step per cycle.
  - Shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient bit when the result is non-negative.
  - Counter decrements each step. The step taken with counter==0 transitions to DONE.
- DONE:
  - ex_div_valid=1 for exactly one cycle.
  - ex_div_out = quotient (DIV/DIVU) or remainder (REM/REMU), sign-corrected:
    - Quotient is negated when the operand signs differ (signed ops).
    - Remainder takes the dividend's sign.
  - Next state is always IDLE. No new accept happens in DONE, even though id_div_valid is still high for the same instruction.
- ex_div_out holds its value outside DONE; only ex_div_valid qualifies it.
- ex_div_stall = (IDLE & id_div_valid & ~flush) | CALC. It is 0 in DONE, so the pipeline advances on the cycle the result is valid.
- Latency: accept in cycle T.
  - Normal: ex_div_valid in cycle T+XLEN+1 (T+33 for XLEN=32).
  - Special case: ex_div_valid in cycle T+1.
- Back-to-back: a new divide in ID/EX the cycle after DONE is accepted from IDLE normally. The result throughput gap is 1 IDLE cycle.
- flush:
  - In any state, forces IDLE next cycle and suppresses ex_div_valid, including a flush during DONE.
  - flush in IDLE blocks an accept.
  - flush has priority over accept.
- Arithmetic: internal remainder register is XLEN+1 bits for the trial subtract. Sign correction uses two's-complement negate at XLEN bits, wrapping.
- Reset mid-CALC: immediate return to IDLE; no ex_div_valid pulse afterwards.

Decomposition:
- Shared core header (core.vh) holds:
  - DIV_OP_DIV/DIVU/REM/REMU encodings.
  - State encodings DIV_IDLE/DIV_CALC/DIV_DONE.
  - XLEN-derived range macro for the counter width, clog2(XLEN).
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
- The sequencer owns the FSM, counter, sign handling and special cases.

Test Plan:
- DIV 100/7 accepted at T → ex_div_stall=1 for T..T+32, ex_div_valid=1 at T+33 with ex_div_out=14; REM same operands → 2.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; REMU 0xFFFFFFFF/2 → 1.
- DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5 at T+1; DIV 0x80000000/-1 → 0x80000000 at T+1, REM → 0.
- flush pulsed at T+10 of a 100/7 divide → state IDLE at T+11, no ex_div_valid ever; next DIV 9/3 accepted normally → 3 at its T+33.
- Two consecutive DIVs (20/4 then 21/5) → valid pulses 34 cycles apart, outputs 5 then 4; exactly one pulse per instruction.
- rst driven low at T+5 asynchronously → ex_div_valid=0, ex_div_stall=0 (no request) immediately; after release, 6/3 → 2 at T'+33.
